// File: rtl/debug_word_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : debug_word_tx_queue
// Purpose  : Queues debug result words and serialises them MSB-first into
//            UART bytes using a start/done handshake.
// Option   : DEBUG_TX_CHECKSUM_EN appends an XOR checksum byte to each word.
// Revision : 1.0
// ============================================================================
module debug_word_tx_queue #(
    parameter int NB_DATA    = 32,
    parameter int NB_BYTE    = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int NB_PTR     = $clog2(FIFO_DEPTH)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_word_valid,
    input  logic [NB_DATA-1:0] i_word,
    output logic               o_word_ready,
    input  logic               i_flush,
    output logic               o_byte_start,
    output logic [NB_BYTE-1:0] o_byte,
    input  logic               i_byte_done,
    output logic               o_word_done_pulse,
    output logic               o_busy,
    output logic [NB_PTR:0]    o_fifo_count,
    output logic               o_overflow
);
    localparam int                 NB_WORD   = NB_DATA / NB_BYTE;
    localparam int                 NB_BCNT   = (NB_WORD > 1) ? $clog2(NB_WORD) : 1;
    localparam logic [NB_PTR:0]    FULL_CNT  = (NB_PTR+1)'(FIFO_DEPTH);
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_WORD - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
`ifdef DEBUG_TX_CHECKSUM_EN
        ,
        ST_CHK      = 3'd5,
        ST_CHK_WAIT = 3'd6
`endif
    } state_t;

    state_t               state_q;
    logic [NB_DATA-1:0]   mem_q [FIFO_DEPTH];
    logic [NB_PTR-1:0]    wr_ptr_q;
    logic [NB_PTR-1:0]    rd_ptr_q;
    logic [NB_PTR:0]      cnt_q;
    logic [NB_PTR:0]      cnt_d;
    logic [NB_DATA-1:0]   shift_q;
    logic [NB_DATA-1:0]   shift_d;
    logic [NB_BCNT-1:0]   bcnt_q;
    logic [NB_BYTE-1:0]   byte_q;
    logic                 start_q;
    logic                 wdone_q;
    logic                 ovf_q;
`ifdef DEBUG_TX_CHECKSUM_EN
    logic [NB_BYTE-1:0]   xor_q;
`endif

    logic push_w;
    logic pop_w;

    assign o_word_ready      = (cnt_q != FULL_CNT);
    assign o_busy            = (state_q != ST_IDLE);
    assign o_fifo_count      = cnt_q;
    assign o_byte            = byte_q;
    assign o_byte_start      = start_q;
    assign o_word_done_pulse = wdone_q;
    assign o_overflow        = ovf_q;

    // The pop happens on the edge that enters LOAD, from either IDLE or DONE.
    assign push_w  = i_word_valid && o_word_ready && !i_flush;
    assign pop_w   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && (cnt_q != '0) && !i_flush;
    assign shift_d = shift_q << NB_BYTE;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_w, pop_w})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= i_word;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
            if (i_word_valid && !o_word_ready) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bcnt_q  <= '0;
            byte_q  <= '0;
            start_q <= 1'b0;
            wdone_q <= 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else if (i_flush) begin
            // o_byte is left alone: the UART may still be shifting it out.
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            wdone_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            wdone_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (pop_w) begin
                        state_q <= ST_LOAD;
                        shift_q <= mem_q[rd_ptr_q];
                        bcnt_q  <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
                        xor_q   <= '0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_SEND;
                    start_q <= 1'b1;
                    byte_q  <= shift_q[NB_DATA-1 -: NB_BYTE];
                end
                ST_SEND: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (i_byte_done) begin
`ifdef DEBUG_TX_CHECKSUM_EN
                        xor_q <= xor_q ^ byte_q;
`endif
                        if (bcnt_q == LAST_BYTE) begin
`ifdef DEBUG_TX_CHECKSUM_EN
                            state_q <= ST_CHK;
                            start_q <= 1'b1;
                            byte_q  <= xor_q ^ byte_q;
`else
                            state_q <= ST_DONE;
                            wdone_q <= 1'b1;
`endif
                        end else begin
                            state_q <= ST_SEND;
                            start_q <= 1'b1;
                            shift_q <= shift_d;
                            bcnt_q  <= bcnt_q + 1'b1;
                            byte_q  <= shift_d[NB_DATA-1 -: NB_BYTE];
                        end
                    end
                end
`ifdef DEBUG_TX_CHECKSUM_EN
                ST_CHK: state_q <= ST_CHK_WAIT;
                ST_CHK_WAIT: begin
                    if (i_byte_done) begin
                        state_q <= ST_DONE;
                        wdone_q <= 1'b1;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_word_tx_queue.sv
`default_nettype none
// Bench for debug_word_tx_queue: directed scenarios plus a randomized run,
// checked against a byte-sequence model built from queued words.
module tb_debug_word_tx_queue;
`ifdef DEBUG_TX_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int BPW = 4 + (CHK ? 1 : 0);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] word = '0;
    logic        bdone = 1'b0;
    logic        ready, bstart, wdone, busy, ovf;
    logic [7:0]  bbyte;
    logic [3:0]  cnt;

    logic        valid2 = 1'b0;
    logic [15:0] word2 = '0;
    logic        bdone2 = 1'b0;
    logic        ready2, bstart2, wdone2, busy2, ovf2;
    logic [7:0]  byte2;
    logic [2:0]  cnt2;

    int n_checks = 0, n_fail = 0;
    int n_wdone = 0, n_wdone2 = 0, exp_wdone = 0;

    logic [7:0] exp_q[$];
    bit         last_q[$];

    always #5 clk = ~clk;

    debug_word_tx_queue u_dut (
        .i_clock(clk), .i_reset(rst_n), .i_word_valid(valid), .i_word(word),
        .o_word_ready(ready), .i_flush(flush), .o_byte_start(bstart), .o_byte(bbyte),
        .i_byte_done(bdone), .o_word_done_pulse(wdone), .o_busy(busy),
        .o_fifo_count(cnt), .o_overflow(ovf)
    );

    debug_word_tx_queue #(.NB_DATA(16), .FIFO_DEPTH(4)) u_dut16 (
        .i_clock(clk), .i_reset(rst_n), .i_word_valid(valid2), .i_word(word2),
        .o_word_ready(ready2), .i_flush(flush), .o_byte_start(bstart2), .o_byte(byte2),
        .i_byte_done(bdone2), .o_word_done_pulse(wdone2), .o_busy(busy2),
        .o_fifo_count(cnt2), .o_overflow(ovf2)
    );

    always @(negedge clk) begin
        if (wdone)  n_wdone++;
        if (wdone2) n_wdone2++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected byte stream: MSB-first bytes of the word, then the XOR of them.
    function automatic void model_push(input logic [31:0] w);
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        for (int i = 3; i >= 0; i--) begin
            b = 8'(w >> (8 * i));
            exp_q.push_back(b);
            last_q.push_back(!CHK && (i == 0));
            x ^= b;
        end
        if (CHK) begin
            exp_q.push_back(x);
            last_q.push_back(1'b1);
        end
    endfunction

    task automatic wait_start(input int budget, output bit ok);
        int n = 0;
        while (!bstart && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = bstart;
        if (!ok) check("start_timeout", 0, 1);
    endtask

    task automatic serve(input int nbytes, input int dly, input bit started);
        bit         ok;
        bit         l;
        logic [7:0] b;
        logic [7:0] e;
        for (int i = 0; i < nbytes; i++) begin
            if (!(started && i == 0)) begin
                wait_start(60, ok);
                if (!ok) return;
            end
            if (exp_q.size() == 0) begin
                check("model_empty", 1, 0);
                return;
            end
            e = exp_q.pop_front();
            l = last_q.pop_front();
            check("byte", bbyte, e);
            b = bbyte;
            @(negedge clk);
            check("start_one_cycle", bstart, 0);
            repeat (dly) @(negedge clk);
            check("byte_hold", bbyte, b);
            bdone = 1'b1;
            @(negedge clk);
            bdone = 1'b0;
            if (l) begin
                check("word_done", wdone, 1);
                exp_wdone++;
            end
        end
    endtask

    initial begin : main
        bit         ok;
        bit         saw;
        int         stray;
        logic [7:0] e2[$];
        bit         prod_done;

        repeat (3) @(negedge clk);
        check("rst_start", bstart, 0);
        check("rst_byte", bbyte, 0);
        check("rst_wdone", wdone, 0);
        check("rst_busy", busy, 0);
        check("rst_count", cnt, 0);
        check("rst_ready", ready, 1);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, latency and ordering
        model_push(32'h11223344);
        valid = 1'b1; word = 32'h11223344;
        @(negedge clk);
        valid = 1'b0;
        check("lat_c1_start", bstart, 0);
        @(negedge clk);
        check("lat_c2_start", bstart, 0);
        check("lat_c2_busy", busy, 1);
        @(negedge clk);
        check("lat_c3_start", bstart, 1);
        serve(BPW, 5, 1'b1);
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Stalled UART: fill, overflow, then drain
        saw = 1'b0;
        for (int i = 0; i < 9; i++) begin
            valid = 1'b1; word = 32'hA0 + 32'(i);
            model_push(word);
            @(negedge clk);
            if (bstart) saw = 1'b1;
        end
        check("stall_first_start", saw, 1);
        check("full_count", cnt, 8);
        check("full_ready", ready, 0);
        word = 32'hA9;
        @(negedge clk);
        valid = 1'b0;
        check("ovf_set", ovf, 1);
        check("ovf_count", cnt, 8);
        serve(9 * BPW, $urandom_range(1, 3), 1'b1);
        @(negedge clk);
        check("drain_busy", busy, 0);
        check("drain_count", cnt, 0);
        check("ovf_sticky", ovf, 1);

        // Flush mid-word with a simultaneous push
        model_push(32'hDEADBEEF);
        valid = 1'b1; word = 32'hDEADBEEF;
        @(negedge clk);
        valid = 1'b0;
        serve(2, 2, 1'b0);
        check("pre_flush_start", bstart, 1);
        flush = 1'b1; valid = 1'b1; word = 32'h12345678;
        @(negedge clk);
        flush = 1'b0; valid = 1'b0;
        exp_q.delete(); last_q.delete();
        check("flush_count", cnt, 0);
        check("flush_ovf", ovf, 0);
        check("flush_busy", busy, 0);
        check("flush_start", bstart, 0);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bstart || wdone) stray++;
        end
        check("flush_quiet", stray, 0);
        check("flush_push_dropped", cnt, 0);

        // Asynchronous reset during WAIT of byte 3
        model_push(32'h55667788);
        valid = 1'b1; word = 32'h55667788;
        @(negedge clk);
        word = 32'h99AABBCC;
        @(negedge clk);
        valid = 1'b0;
        serve(2, 2, 1'b0);
        wait_start(20, ok);
        @(negedge clk);
        check("pre_rst_count", cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_start", bstart, 0);
        check("arst_byte", bbyte, 0);
        check("arst_wdone", wdone, 0);
        check("arst_busy", busy, 0);
        check("arst_count", cnt, 0);
        check("arst_ready", ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete(); last_q.delete();
        @(negedge clk);
        model_push(32'hCAFEF00D);
        valid = 1'b1; word = 32'hCAFEF00D;
        @(negedge clk);
        valid = 1'b0;
        serve(BPW, 1, 1'b0);

        // 16-bit instance, back-to-back words
        e2 = {8'hBE, 8'hEF};
        if (CHK) e2.push_back(8'h51);
        e2.push_back(8'h01); e2.push_back(8'h02);
        if (CHK) e2.push_back(8'h03);
        n_wdone2 = 0;
        valid2 = 1'b1; word2 = 16'hBEEF;
        @(negedge clk);
        word2 = 16'h0102;
        @(negedge clk);
        valid2 = 1'b0;
        foreach (e2[k]) begin
            int n = 0;
            while (!bstart2 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("w16_byte", byte2, e2[k]);
            repeat (2) @(negedge clk);
            bdone2 = 1'b1;
            @(negedge clk);
            bdone2 = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("w16_word_done", n_wdone2, 2);
        check("w16_busy", busy2, 0);

        // Randomized traffic
        prod_done = 1'b0;
        fork
            begin : producer
                int k = 0;
                while (k < 30) begin
                    if ($urandom_range(0, 2) != 0 && ready) begin
                        valid = 1'b1;
                        word  = $urandom;
                        model_push(word);
                        k++;
                    end else begin
                        valid = 1'b0;
                    end
                    @(negedge clk);
                end
                valid = 1'b0;
                prod_done = 1'b1;
            end
            begin : responder
                int         guard = 0;
                logic [7:0] b;
                logic [7:0] e;
                bit         l;
                while (!(prod_done && exp_q.size() == 0) && guard < 20000) begin
                    if (bstart) begin
                        if (exp_q.size() == 0) begin
                            check("rnd_unexpected_start", 1, 0);
                            @(negedge clk);
                        end else begin
                            e = exp_q.pop_front();
                            l = last_q.pop_front();
                            check("rnd_byte", bbyte, e);
                            b = bbyte;
                            @(negedge clk);
                            repeat ($urandom_range(0, 4)) @(negedge clk);
                            check("rnd_hold", bbyte, b);
                            bdone = 1'b1;
                            @(negedge clk);
                            bdone = 1'b0;
                            if (l) begin
                                check("rnd_word_done", wdone, 1);
                                exp_wdone++;
                            end
                        end
                    end else begin
                        @(negedge clk);
                    end
                    guard++;
                end
                if (guard >= 20000) check("rnd_timeout", 0, 1);
            end
        join
        repeat (4) @(negedge clk);
        check("end_busy", busy, 0);
        check("end_count", cnt, 0);
        check("end_ovf", ovf, 0);
        check("total_word_done", n_wdone, exp_wdone);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/debug_word_tx_queue.md
Name: debug_word_tx_queue

Overview:
- Parametrised word-to-byte transmit path for the debug link. It sits between the debug unit, which produces result words (registers, memory, PC), and a byte-level UART transmitter.
- Buffers up to FIFO_DEPTH words and serialises each into NB_DATA/NB_BYTE bytes, MSB first, using a start/done handshake. It pulses once per completed word.
- Generalises the fixed 32-bit, unbuffered word send path to any word width and queue depth. Adds flush, overflow reporting and an optional per-word checksum.

Parameters:
- NB_DATA, 32, word width in bits; must be an integer multiple of NB_BYTE.
- NB_BYTE, 8, UART byte width in bits.
- FIFO_DEPTH, 8, word queue depth; power of two, at least 2.
- NB_PTR, $clog2(FIFO_DEPTH), pointer width; derived, not overridden.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous reset, active-low.
- i_word_valid  in  1  producer offers i_word this cycle.
- i_word  in  NB_DATA  word to queue.
- o_word_ready  out  1  high when the FIFO is not full.
- i_flush  in  1  synchronous clear of queue, FSM and overflow flag.
- o_byte_start  out  1  one-cycle start pulse to the byte UART.
- o_byte  out  NB_BYTE  byte to send; stable from the start pulse until i_byte_done.
- i_byte_done  in  1  one-cycle pulse from the UART when the byte has been sent.
- o_word_done_pulse  out  1  one-cycle pulse when a full word (plus checksum, if enabled) has been sent.
- o_busy  out  1  high when the FSM is not in IDLE.
- o_fifo_count  out  NB_PTR+1  number of words queued.
- o_overflow  out  1  sticky; a write was attempted while full.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - pointers, count and byte counter to 0; FSM to IDLE;
  - o_byte=0, o_byte_start=0, o_word_done_pulse=0, o_busy=0, o_overflow=0, o_word_ready=1.
  - Reset mid-word abandons the word silently.
- Push: occurs on the edge where i_word_valid && o_word_ready && !i_flush.
- Pop: occurs on entry to LOAD.
- Push and pop in the same cycle leave the count unchanged.
- o_word_ready = (count != FIFO_DEPTH), derived from the registered count. At full it stays low for that cycle even if a pop happens.
- Overflow: i_word_valid while full sets o_overflow; the word is dropped and the FIFO is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if count != 0, go to LOAD.
  - LOAD: pop; the shift register takes the head word; byte_cnt=0; go to SEND.
  - SEND: o_byte_start=1 for exactly this cycle; o_byte=shift[NB_DATA-1 -: NB_BYTE]; go to WAIT.
  - WAIT: hold o_byte. On i_byte_done:
    - if byte_cnt = NB_DATA/NB_BYTE-1, go to DONE (or CHK with the macro);
    - otherwise shift left by NB_BYTE, byte_cnt+1, go to SEND.
  - DONE: o_word_done_pulse=1 for one cycle; go to LOAD if count != 0, else IDLE.
- Latency: a word pushed into an empty idle block produces o_byte_start in the second cycle after the accepting edge (IDLE, LOAD, SEND).
- Back-to-back words: the next word's start pulse comes 2 cycles after DONE.
- i_byte_done is ignored outside WAIT.
- Flush (synchronous; has priority over everything except reset):
  - clears pointers, count and o_overflow; FSM to IDLE;
  - o_byte_start deasserts; no o_word_done_pulse for the aborted word.
  - A byte already handed to the UART is not recalled.
  - A simultaneous push is dropped and does not set overflow.
- All outputs are registered except o_word_ready and o_busy, which are decoded from registered state.

Optional Feature:
- Macro: DEBUG_TX_CHECKSUM_EN.
- Defined:
  - the running XOR of every byte sent for the current word is accumulated; it is cleared in LOAD.
  - After the last data byte's i_byte_done, the FSM goes to CHK: o_byte=xor, one-cycle o_byte_start, then a wait state for i_byte_done, then DONE.
  - Each word costs NB_DATA/NB_BYTE+1 bytes.
- Not defined: no CHK states and no accumulator; exactly NB_DATA/NB_BYTE bytes per word.

Test Plan:
1. Defaults. Push 0x11223344 and answer each start with i_byte_done 5 cycles later. Required: bytes 0x11, 0x22, 0x33, 0x44 in order; one o_word_done_pulse after the 4th done; first start 2 cycles after push; o_busy returns to 0.
2. With DEBUG_TX_CHECKSUM_EN, push 0x11223344. Required: 0x11, 0x22, 0x33, 0x44, then 0x44 (the XOR); o_word_done_pulse only after the 5th done.
3. Stall the UART (no i_byte_done) and push 9 words 0xA0..0xA8. Required: o_fifo_count reaches 8 (the first word is popped into LOAD, so 8 remain queued after the 9th is accepted); a 10th push drops the word and sets o_overflow=1. Release done; words are sent in order with no corruption.
4. Mid-word (after byte 2 of 0xDEADBEEF), assert i_flush together with a push of 0x12345678. Required: count=0, overflow cleared, no word_done, no further start pulses, 0x12345678 never sent.
5. Drive i_reset low during WAIT of byte 3. Required: all outputs return to their reset values immediately (asynchronously). After release, a new word 0xCAFEF00D is sent from its first byte, 0xCA.
6. With NB_DATA=16 and FIFO_DEPTH=4, push 0xBEEF and 0x0102 back to back. Required: bytes 0xBE, 0xEF, 0x01, 0x02, with two o_word_done_pulse.
